// File: rtl/wbdbgbus_pkg.sv
// Shared constants and types for the debug-bus transmit path.
// Frame layout helpers used by the tx arbiter.
package wbdbgbus_pkg;

    localparam logic [3:0] RESP_INT_BASE  = 4'b1000;
    localparam logic [3:0] RESP_HEARTBEAT = 4'b1100;
    localparam logic [3:0] CMD_RESET      = 4'b1111;

    localparam int FRAME_BITS  = 40;
    localparam int FRAME_BYTES = 5;
    localparam int WORD_BITS   = 36;

    typedef enum logic {IDLE, SEND} tx_state_t;

    function automatic logic [FRAME_BITS-1:0] code_frame(input logic [3:0] code);
        return {4'b0000, code, 32'h0};
    endfunction

endpackage

// File: rtl/wbdbgbus_fifo.sv
// Synchronous first-word-fall-through FIFO for response words.
// A push to a full FIFO succeeds only when a pop happens in the same cycle.
module wbdbgbus_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wbdbgbus_tx_arbiter.sv
// Debug-bus UART transmit arbiter: response FIFO, interrupt events, 5-byte framing.
// Optional idle heartbeat frames with WBDBGBUS_HEARTBEAT_EN.
module wbdbgbus_tx_arbiter
    import wbdbgbus_pkg::*;
#(
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int NUM_INT         = 4,
    parameter int HEARTBEAT_CLKS  = 25000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_resp_valid,
    input  logic [35:0]        i_resp_data,
    input  logic [NUM_INT-1:0] i_interrupt,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_overflow
);

    logic                  rv_q;
    logic [WORD_BITS-1:0]  rd_q;
    logic [NUM_INT-1:0]    int_q;
    logic [NUM_INT-1:0]    int_last;
    logic [NUM_INT-1:0]    pend;
    logic [NUM_INT-1:0]    pend_clr;
    logic [NUM_INT-1:0]    rise;
    logic [1:0]            int_idx;
    logic [WORD_BITS-1:0]  fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    tx_state_t             state;
    tx_state_t             state_nx;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_frame;
    logic [2:0]            byte_idx;
    logic                  tx_valid;
    logic                  load;
    logic                  load_resp;
    logic                  last_resp;
    logic                  overflow;

    // Inputs are registered once so both sources see the same two-clock latency.
    assign rise     = int_q & ~int_last;
    assign fifo_pop = load_resp;

    wbdbgbus_fifo #(
        .WIDTH(WORD_BITS),
        .DEPTH(RESP_FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .push   (rv_q),
        .wdata  (rd_q),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        int_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                int_idx = 2'(i);
            end
        end
    end

`ifdef WBDBGBUS_HEARTBEAT_EN
    localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_CLKS - 1);
    logic [31:0] hb_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || load) begin
            hb_cnt <= '0;
        end else if (state == IDLE) begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        load_resp  = 1'b0;
        load_frame = '0;
        pend_clr   = '0;
        unique case (state)
            IDLE: begin
                // A pending interrupt jumps the queue right after a response frame.
                if (|pend && (last_resp || fifo_empty)) begin
                    load       = 1'b1;
                    pend_clr   = NUM_INT'(1) << int_idx;
                    load_frame = code_frame(RESP_INT_BASE + {2'b00, int_idx});
                end else if (!fifo_empty) begin
                    load       = 1'b1;
                    load_resp  = 1'b1;
                    load_frame = {4'b0000, fifo_rdata};
                end
`ifdef WBDBGBUS_HEARTBEAT_EN
                else if (hb_cnt >= HB_LAST) begin
                    load       = 1'b1;
                    load_frame = code_frame(RESP_HEARTBEAT);
                end
`endif
                if (load) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (i_tx_ready && byte_idx == 3'(FRAME_BYTES - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rv_q      <= 1'b0;
            rd_q      <= '0;
            int_q     <= i_interrupt;
            int_last  <= i_interrupt;
            pend      <= '0;
            state     <= IDLE;
            shreg     <= '0;
            byte_idx  <= '0;
            tx_valid  <= 1'b0;
            last_resp <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rv_q     <= i_resp_valid;
            rd_q     <= i_resp_data;
            int_q    <= i_interrupt;
            int_last <= int_q;
            pend     <= (pend & ~pend_clr) | rise;
            state    <= state_nx;
            if (rv_q && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (load) begin
                shreg     <= load_frame;
                byte_idx  <= '0;
                tx_valid  <= 1'b1;
                last_resp <= load_resp;
            end else if (state == SEND && i_tx_ready) begin
                shreg    <= shreg << 8;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 3'(FRAME_BYTES - 1)) begin
                    tx_valid <= 1'b0;
                end
            end
        end
    end

    assign o_tx_data  = shreg[FRAME_BITS-1 -: 8];
    assign o_tx_valid = tx_valid;
    assign o_busy     = (state == SEND) || !fifo_empty || |pend;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_wbdbgbus_tx_arbiter.sv
// Self-checking bench for wbdbgbus_tx_arbiter: directed scenarios plus random traffic.
// A queue-based reference model is compared against the outputs every cycle.
module tb_wbdbgbus_tx_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_resp_valid = 1'b0;
    logic [35:0] i_resp_data = '0;
    logic [3:0]  i_interrupt = '0;
    logic        i_tx_ready = 1'b1;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_overflow;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 i_clk = ~i_clk;

    wbdbgbus_tx_arbiter #(
        .RESP_FIFO_DEPTH(4),
        .NUM_INT(4),
        .HEARTBEAT_CLKS(25000000)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_resp_valid(i_resp_valid),
        .i_resp_data (i_resp_data),
        .i_interrupt (i_interrupt),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
    );

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: inputs reach the arbiter one clock after sampling.
    logic [35:0] m_q[$];
    logic [3:0]  m_pend = '0;
    logic        m_active = 1'b0;
    logic [39:0] m_frame = '0;
    int          m_byte = 0;
    logic        m_last_resp = 1'b0;
    logic        m_ovf = 1'b0;
    logic        s_rv = 1'b0;
    logic [35:0] s_rd = '0;
    logic [3:0]  s_int = '0;
    logic [3:0]  s_prev = '0;

    always @(posedge i_clk) begin
        logic [3:0] rise;
        int w;
        if (i_reset) begin
            m_q.delete();
            m_pend = '0;
            m_active = 1'b0;
            m_byte = 0;
            m_last_resp = 1'b0;
            m_ovf = 1'b0;
            s_rv = 1'b0;
            s_int = i_interrupt;
            s_prev = i_interrupt;
        end else begin
            rise = s_int & ~s_prev;
            if (m_active) begin
                if (i_tx_ready) begin
                    if (m_byte == 4) m_active = 1'b0;
                    else m_byte++;
                end
            end else if (m_pend != 0 && (m_last_resp || m_q.size() == 0)) begin
                w = 0;
                for (int i = 3; i >= 0; i--) if (m_pend[i]) w = i;
                m_pend[w] = 1'b0;
                m_frame = {4'h0, 4'(8 + w), 32'h0};
                m_active = 1'b1;
                m_byte = 0;
                m_last_resp = 1'b0;
            end else if (m_q.size() != 0) begin
                m_frame = {4'h0, m_q.pop_front()};
                m_active = 1'b1;
                m_byte = 0;
                m_last_resp = 1'b1;
            end
            if (s_rv) begin
                if (m_q.size() < 4) m_q.push_back(s_rd);
                else m_ovf = 1'b1;
            end
            m_pend = m_pend | rise;
            s_prev = s_int;
            s_int = i_interrupt;
            s_rv = i_resp_valid;
            s_rd = i_resp_data;
        end
    end

    logic [7:0] cap[$];
    logic [7:0] expb[$];

    always @(negedge i_clk) begin
        if (chk_on) begin
            chk("tx_valid", 40'(o_tx_valid), 40'(m_active));
            if (m_active) chk("tx_data", 40'(o_tx_data), 40'(m_frame[39-8*m_byte -: 8]));
            chk("busy", 40'(o_busy), 40'(m_active || m_q.size() != 0 || m_pend != 0));
            chk("overflow", 40'(o_overflow), 40'(m_ovf));
            if (o_tx_valid && i_tx_ready && !i_reset) cap.push_back(o_tx_data);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input logic [35:0] d);
        i_resp_valid = 1'b1;
        i_resp_data = d;
        tick();
        i_resp_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!o_tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 40'(o_tx_valid), 40'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (3) tick();
        while ((o_busy || o_tx_valid) && n < 500) begin
            tick();
            n++;
        end
        chk(nm, 40'(o_busy || o_tx_valid), 40'd0);
    endtask

    task automatic add_frame(input logic [39:0] f);
        for (int k = 0; k < 5; k++) expb.push_back(f[39-8*k -: 8]);
    endtask

    task automatic cmp_cap(input string nm);
        chk({nm, "_len"}, 40'(cap.size()), 40'(expb.size()));
        for (int k = 0; k < expb.size() && k < cap.size(); k++)
            chk(nm, 40'(cap[k]), 40'(expb[k]));
        cap.delete();
        expb.delete();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        cap.delete();
    endtask

    initial begin
        logic [7:0] held;
        tick();
        chk_on = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst_valid", 40'(o_tx_valid), 40'd0);
        chk("rst_data", 40'(o_tx_data), 40'd0);
        chk("rst_busy", 40'(o_busy), 40'd0);
        chk("rst_ovf", 40'(o_overflow), 40'd0);

        // single response and its latency
        strobe(36'h1_DEADBEEF);
        chk("lat_n0", 40'(o_tx_valid), 40'd0);
        tick();
        chk("lat_n1", 40'(o_tx_valid), 40'd0);
        tick();
        chk("lat_n2", 40'(o_tx_valid), 40'd1);
        wait_idle("t1_idle");
        expb = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cmp_cap("t1_bytes");

        // back-pressure mid-frame
        strobe(36'h3_12345678);
        wait_valid("t2_start");
        tick();
        tick();
        i_tx_ready = 1'b0;
        held = o_tx_data;
        chk("t2_byte2", 40'(held), 40'h34);
        repeat (10) begin
            tick();
            chk("t2_hold_data", 40'(o_tx_data), 40'h34);
            chk("t2_hold_valid", 40'(o_tx_valid), 40'd1);
        end
        i_tx_ready = 1'b1;
        wait_idle("t2_idle");
        add_frame(40'h03_1234_5678);
        cmp_cap("t2_bytes");

        // overflow while a frame is stalled
        i_tx_ready = 1'b0;
        strobe(36'h5_000000A0);
        wait_valid("t3_start");
        for (int i = 1; i <= 6; i++) strobe(36'h5_000000A0 + 36'(i));
        repeat (3) tick();
        chk("t3_ovf", 40'(o_overflow), 40'd1);
        i_tx_ready = 1'b1;
        wait_idle("t3_idle");
        for (int i = 0; i <= 4; i++) add_frame({4'h0, 36'h5_000000A0 + 36'(i)});
        cmp_cap("t3_bytes");
        chk("t3_ovf_sticky", 40'(o_overflow), 40'd1);
        do_reset();
        chk("t3_ovf_clr", 40'(o_overflow), 40'd0);

        // interrupt jumps ahead of queued responses
        i_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(36'h7_00000B00 + 36'(i));
        i_interrupt[2] = 1'b1;
        repeat (4) tick();
        i_tx_ready = 1'b1;
        wait_idle("t4_idle");
        i_interrupt[2] = 1'b0;
        add_frame(40'h07_0000_0B00);
        add_frame(40'h0A_0000_0000);
        for (int i = 1; i < 4; i++) add_frame({4'h0, 36'h7_00000B00 + 36'(i)});
        cmp_cap("t4_bytes");

        // coalesced interrupt edges
        i_tx_ready = 1'b0;
        strobe(36'h9_CAFEF00D);
        wait_valid("t5_start");
        repeat (3) begin
            i_interrupt[0] = 1'b1;
            tick();
            tick();
            i_interrupt[0] = 1'b0;
            tick();
            tick();
        end
        i_tx_ready = 1'b1;
        wait_idle("t5_idle");
        add_frame(40'h09_CAFE_F00D);
        add_frame(40'h08_0000_0000);
        cmp_cap("t5_bytes");

        // reset mid-frame with an interrupt level held
        strobe(36'h2_55AA55AA);
        i_interrupt[1] = 1'b1;
        for (int n = 0; n < 50 && cap.size() < 2; n++) tick();
        chk("t6_two_bytes", 40'(cap.size()), 40'd2);
        i_reset = 1'b1;
        tick();
        chk("t6_valid", 40'(o_tx_valid), 40'd0);
        chk("t6_busy", 40'(o_busy), 40'd0);
        i_reset = 1'b0;
        cap.delete();
        repeat (20) tick();
        chk("t6_no_frame", 40'(cap.size()), 40'd0);
        i_interrupt = '0;
        tick();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            i_resp_valid = ($urandom % 4) == 0;
            i_resp_data = {4'($urandom), 32'($urandom)};
            for (int b = 0; b < 4; b++)
                if ($urandom % 16 == 0) i_interrupt[b] = ~i_interrupt[b];
            i_tx_ready = ($urandom % 4) != 0;
            i_reset = ($urandom % 400) == 0;
            tick();
        end
        i_reset = 1'b0;
        i_resp_valid = 1'b0;
        i_tx_ready = 1'b1;
        wait_idle("rand_drain");
        cap.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
